// File: rtl/tetris_pkg.sv
// Shared playfield constants and scanner types for the tetromino placement logic.
package tetris_pkg;

    // Playfield geometry and board RAM address width.
    localparam int BOARD_W    = 10;
    localparam int BOARD_H    = 20;
    localparam int ADDR_W     = 8;

    // One piece window is 4x4 cells, scanned row-major.
    localparam int SCAN_CELLS = 16;

    // Cell code meaning "nothing here", used by both the template ROM and the board RAM.
    localparam logic [1:0] CELL_EMPTY = 2'b11;

    // Scanner control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // CHECK probes the board for a collision; LOCK stamps the piece into it.
    typedef enum logic {
        MODE_CHECK = 1'b0,
        MODE_LOCK  = 1'b1
    } scan_mode_t;

    // Per-cell facts carried one cycle so they line up with the registered board read.
    typedef struct packed {
        logic occ;
        logic off_side;
        logic hidden;
    } cell_stage_t;

endpackage

// File: rtl/board_coord_map.sv
// Maps a piece-window cell onto the playfield: linear board address plus legality flags.
// Purely combinational; signed 7-bit arithmetic so window origins left of / above the board work.
module board_coord_map #(
    parameter int BOARD_W = tetris_pkg::BOARD_W,
    parameter int BOARD_H = tetris_pkg::BOARD_H,
    parameter int ADDR_W  = tetris_pkg::ADDR_W
) (
    input  logic [4:0]        x,        // signed window-origin column
    input  logic [5:0]        y,        // signed window-origin row
    input  logic [1:0]        col,      // window column 0..3
    input  logic [1:0]        row,      // window row 0..3
    output logic [ADDR_W-1:0] addr,     // row*BOARD_W + col, 0 when not on the board
    output logic              off_side, // left, right or below the board
    output logic              hidden    // above the board (spawn area)
);

    logic [6:0] bx;
    logic [6:0] by;
    logic       in_board;

    // Cell position on the board and its classification.
    always_comb begin
        bx       = {{2{x[4]}}, x} + {5'b0, col};
        by       = {y[5], y} + {5'b0, row};
        hidden   = by[6];
        // A negative column also has a large magnitude in bx[5:0], but the sign bit alone decides it.
        off_side = bx[6]
                 | (bx[5:0] >= 6'(BOARD_W))
                 | (!by[6] && (by[5:0] >= 6'(BOARD_H)));
        in_board = !off_side && !hidden;
        addr     = '0;
        if (in_board) begin
            addr = ADDR_W'(by[5:0]) * ADDR_W'(BOARD_W) + ADDR_W'(bx[5:0]);
        end
    end

endmodule

// File: rtl/piece_board_scanner.sv
// Walks one tetromino's 4x4 window cell by cell against the template ROM and the playfield RAM.
// CHECK mode accumulates a collision flag; LOCK mode writes the piece colour into the board.
// Fixed latency: start sampled at E0, one capture cycle, 16 SCAN cycles, FLUSH, DONE.
module piece_board_scanner #(
    parameter int BOARD_W = tetris_pkg::BOARD_W,
    parameter int BOARD_H = tetris_pkg::BOARD_H,
    parameter int ADDR_W  = tetris_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [2:0]        piece_id,
    input  logic [1:0]        rot,
    input  logic [4:0]        piece_x,
    input  logic [5:0]        piece_y,
    output logic              busy,
    output logic              done,
    output logic              collide,
    output logic [4:0]        rom_identifier,
    output logic [2:0]        rom_col,
    output logic [2:0]        rom_row,
    input  logic [1:0]        rom_template,
    output logic [ADDR_W-1:0] brd_addr,
    input  logic [1:0]        brd_rd_data,
    output logic              brd_we,
    output logic [1:0]        brd_wr_data
);

    import tetris_pkg::*;

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic              launch;     // start accepted last edge; SCAN begins next edge
    logic              accept;
    scan_mode_t        mode_q;
    logic [4:0]        ident_q;
    logic [4:0]        x_q;
    logic [5:0]        y_q;
    logic [3:0]        cnt;        // cell index k: row = k[3:2], col = k[1:0]
    logic              scanning;
    logic              occ;
    logic [ADDR_W-1:0] cell_addr;
    logic              cell_off_side;
    logic              cell_hidden;
    cell_stage_t       stage;
    logic              stage_vld;
    logic              stage_hit;
    logic              acc;        // sticky collision accumulator for the running scan
    logic              collide_q;  // published result, held until the next accepted start

    assign accept   = (state == ST_IDLE) && !launch && start;
    assign scanning = (state == ST_SCAN);
    assign occ      = (rom_template != CELL_EMPTY);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign collide  = collide_q;

    board_coord_map #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .ADDR_W  (ADDR_W)
    ) u_map (
        .x        (x_q),
        .y        (y_q),
        .col      (cnt[1:0]),
        .row      (cnt[3:2]),
        .addr     (cell_addr),
        .off_side (cell_off_side),
        .hidden   (cell_hidden)
    );

    // Capture the placement request so later input changes cannot disturb the scan.
    // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            launch  <= 1'b0;
            mode_q  <= MODE_CHECK;
            ident_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (accept) begin
            launch  <= 1'b1;
            mode_q  <= scan_mode_t'(mode);
            ident_q <= {piece_id, rot};
            x_q     <= piece_x;
            y_q     <= piece_y;
        end else begin
            launch  <= 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed-length walk, no early exit; a start seen in DONE is dropped.
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (launch) state_nxt = ST_SCAN;
            ST_SCAN:  if (cnt == 4'(SCAN_CELLS - 1)) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Cell index advances once per SCAN cycle and parks at zero otherwise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (scanning) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= '0;
        end
    end

    // ROM and board drive: outputs sit at zero outside SCAN; writes are issued in the cell's own cycle.
    // brd_we is decoded from the asynchronously reset state, so it drops the moment Reset_n falls.
    always_comb begin
        rom_identifier = '0;
        rom_col        = '0;
        rom_row        = '0;
        brd_addr       = '0;
        brd_we         = 1'b0;
        brd_wr_data    = '0;
        if (scanning) begin
            rom_identifier = ident_q;
            rom_col        = {1'b0, cnt[1:0]};
            rom_row        = {1'b0, cnt[3:2]};
            brd_addr       = cell_addr;
            if (mode_q == MODE_LOCK) begin
                brd_we      = occ && !cell_off_side && !cell_hidden;
                brd_wr_data = rom_template;
            end
        end
    end

    // One-stage pipeline aligning cell k's flags with the board data read back during k+1.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stage     <= '0;
            stage_vld <= 1'b0;
        end else begin
            stage_vld <= scanning;
            stage     <= '{occ: occ, off_side: cell_off_side, hidden: cell_hidden};
        end
    end

    // Collision contribution of the staged cell; hidden cells only matter when locking.
    always_comb begin
        stage_hit = 1'b0;
        if (stage_vld && stage.occ) begin
            if (mode_q == MODE_LOCK) begin
                stage_hit = stage.off_side || stage.hidden;
            end else begin
                stage_hit = stage.off_side || (!stage.hidden && (brd_rd_data != CELL_EMPTY));
            end
        end
    end

    // Sticky accumulator; the result only becomes visible when DONE is entered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc       <= 1'b0;
            collide_q <= 1'b0;
        end else if (accept) begin
            acc       <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            if (stage_hit) begin
                acc <= 1'b1;
            end
            if (state == ST_FLUSH) begin
                collide_q <= acc || stage_hit;
            end
        end
    end

endmodule

// File: tb/tb_piece_board_scanner.sv
// Scoreboard bench for piece_board_scanner: the driver pushes expected results and writes,
// a negedge monitor pops and compares them whenever the DUT shows done or brd_we.
module tb_piece_board_scanner;

    localparam int AW    = 8;
    localparam int CELLS = 200;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [2:0]    piece_id = '0;
    logic [1:0]    rot = '0;
    logic [4:0]    piece_x = '0;
    logic [5:0]    piece_y = '0;
    logic          busy;
    logic          done;
    logic          collide;
    logic [4:0]    rom_identifier;
    logic [2:0]    rom_col;
    logic [2:0]    rom_row;
    logic [1:0]    rom_template;
    logic [AW-1:0] brd_addr;
    logic [1:0]    brd_rd_data;
    logic          brd_we;
    logic [1:0]    brd_wr_data;

    always #5 Clk = ~Clk;

    piece_board_scanner dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .start          (start),
        .mode           (mode),
        .piece_id       (piece_id),
        .rot            (rot),
        .piece_x        (piece_x),
        .piece_y        (piece_y),
        .busy           (busy),
        .done           (done),
        .collide        (collide),
        .rom_identifier (rom_identifier),
        .rom_col        (rom_col),
        .rom_row        (rom_row),
        .rom_template   (rom_template),
        .brd_addr       (brd_addr),
        .brd_rd_data    (brd_rd_data),
        .brd_we         (brd_we),
        .brd_wr_data    (brd_wr_data)
    );

    // Template ROM model: 16-bit occupancy masks, bit k = row*4+col.
    function automatic logic [1:0] tmpl(input logic [4:0] ident, input logic [2:0] c, input logic [2:0] r);
        logic [15:0] mask;
        logic [1:0]  colour;
        logic [3:0]  k;
        mask   = '0;
        colour = 2'b11;
        case (ident)
            {3'd0, 2'd0}: begin mask = 16'h0660; colour = 2'b00; end // O
            {3'd1, 2'd0}: begin mask = 16'h00F0; colour = 2'b01; end // I horizontal, row 1
            {3'd1, 2'd1}: begin mask = 16'h2222; colour = 2'b01; end // I vertical, col 1
            {3'd3, 2'd0}: begin mask = 16'h0036; colour = 2'b10; end // S
            {3'd4, 2'd0}: begin mask = 16'h0072; colour = 2'b01; end // T
            {3'd6, 2'd1}: begin mask = 16'h0622; colour = 2'b00; end // L
            default: ;
        endcase
        k = {r[1:0], c[1:0]};
        return mask[k] ? colour : 2'b11;
    endfunction

    always_comb rom_template = tmpl(rom_identifier, rom_col, rom_row);

    // Registered board RAM model with bench-side clear/preload ports.
    logic [1:0]    board [0:CELLS-1];
    logic          clear_req = 1'b0;
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [1:0]    pre_data = '0;

    always @(posedge Clk) begin
        if (clear_req) begin
            for (int i = 0; i < CELLS; i++) board[i] <= 2'b11;
        end else if (pre_en) begin
            board[pre_addr] <= pre_data;
        end else if (brd_we && (int'(brd_addr) < CELLS)) begin
            board[brd_addr] <= brd_wr_data;
        end
        brd_rd_data <= (int'(brd_addr) < CELLS) ? board[brd_addr] : 2'b11;
    end

    // Scoreboard state.
    typedef struct packed {
        logic        collide;
        logic [31:0] cyc;
    } exp_done_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [1:0] data;
    } exp_wr_t;

    exp_done_t   done_q[$];
    exp_wr_t     wr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          scans_done = 0;
    int          scans_target = 0;
    logic [31:0] cyc = 0;
    logic        done_prev = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every write strobe and every done pulse.
    always @(negedge Clk) begin
        exp_wr_t   w;
        exp_done_t e;
        if (Reset_n) begin
            if (brd_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write_addr", brd_addr, 32'hFFFF_FFFF);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", brd_addr, w.addr);
                    check("wr_data", brd_wr_data, w.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done_cycle", cyc, 32'hFFFF_FFFF);
                end else begin
                    e = done_q.pop_front();
                    check("collide", collide, e.collide);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_at_done", busy, 1);
                    check("done_single_pulse", done_prev, 0);
                    check("writes_outstanding", wr_q.size(), 0);
                end
                scans_done++;
            end
        end
        done_prev <= Reset_n && done;
    end

    task automatic push_wr(input int a, input logic [1:0] d);
        wr_q.push_back('{addr: 8'(a), data: d});
    endtask

    task automatic clear_board();
        @(posedge Clk); #1;
        clear_req = 1'b1;
        @(posedge Clk); #1;
        clear_req = 1'b0;
    endtask

    task automatic preload(input int a, input logic [1:0] d);
        @(posedge Clk); #1;
        pre_en = 1'b1; pre_addr = AW'(a); pre_data = d;
        @(posedge Clk); #1;
        pre_en = 1'b0;
    endtask

    // Present one request for one cycle, then scramble the captured inputs.
    // Start is sampled at E0, so done appears in the cycle after E18.
    task automatic issue(input logic m, input logic [2:0] pid, input logic [1:0] r,
                         input int x, input int y, input logic exp_c);
        @(posedge Clk); #1;
        mode = m; piece_id = pid; rot = r;
        piece_x = 5'(x); piece_y = 6'(y);
        start = 1'b1;
        done_q.push_back('{collide: exp_c, cyc: cyc + 32'd19});
        @(posedge Clk); #1;
        start = 1'b0;
        mode = ~m; piece_id = 3'd5; rot = ~r;
        piece_x = 5'(x + 5); piece_y = 6'(y + 7);
        check("collide_cleared_on_start", collide, 0);
        check("busy_capture_cycle", busy, 0);
    endtask

    task automatic wait_scans(input int budget);
        int n;
        n = 0;
        while (scans_done < scans_target && n < budget) begin
            @(posedge Clk);
            n++;
        end
        check("scan_completed", scans_done, scans_target);
        if (scans_done < scans_target) begin
            done_q.delete();
            wr_q.delete();
            scans_target = scans_done;
        end
    endtask

    task automatic run(input logic m, input logic [2:0] pid, input logic [1:0] r,
                       input int x, input int y, input logic exp_c);
        issue(m, pid, r, x, y, exp_c);
        scans_target++;
        repeat (10) @(posedge Clk);
        #1;
        check("collide_hidden_midscan", collide, 0);
        check("busy_midscan", busy, 1);
        wait_scans(40);
        repeat (2) @(posedge Clk);
        #1;
        check("collide_held", collide, exp_c);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int n0;
        // Reset values while Reset_n is low.
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_collide", collide, 0);
        check("rst_brd_we", brd_we, 0);
        check("rst_brd_addr", brd_addr, 0);
        check("rst_brd_wr_data", brd_wr_data, 0);
        check("rst_rom_identifier", rom_identifier, 0);
        check("rst_rom_col", rom_col, 0);
        check("rst_rom_row", rom_row, 0);
        Reset_n = 1'b1;
        clear_board();

        // T on an empty board: no collision, no writes.
        run(1'b0, 3'd4, 2'd0, 3, 0, 1'b0);

        // Vertical I: column 1 at x=-2 lands on bx=-1; at x=-1 it fits.
        run(1'b0, 3'd1, 2'd1, -2, 0, 1'b1);
        run(1'b0, 3'd1, 2'd1, -1, 0, 1'b0);

        // O near the floor: occupied (5,19) hits, (7,19) does not, row 20 is off the board.
        preload(195, 2'b00);
        run(1'b0, 3'd0, 2'd0, 4, 17, 1'b1);
        clear_board();
        preload(197, 2'b00);
        run(1'b0, 3'd0, 2'd0, 4, 17, 1'b0);
        clear_board();
        run(1'b0, 3'd0, 2'd0, 4, 18, 1'b1);
        // Right wall: cols 9,10 illegal, cols 8,9 legal.
        run(1'b0, 3'd0, 2'd0, 8, 0, 1'b1);
        run(1'b0, 3'd0, 2'd0, 7, 0, 1'b0);

        // LOCK S fully on the board, then one row lower with half of it below the floor.
        push_wr(181, 2'b10); push_wr(182, 2'b10); push_wr(190, 2'b10); push_wr(191, 2'b10);
        run(1'b1, 3'd3, 2'd0, 0, 18, 1'b0);
        clear_board();
        push_wr(191, 2'b10); push_wr(192, 2'b10);
        run(1'b1, 3'd3, 2'd0, 0, 19, 1'b1);

        // L straddling the spawn area: hidden cells read address 0 (occupied) but never collide.
        clear_board();
        preload(0, 2'b01);
        run(1'b0, 3'd6, 2'd1, 3, -2, 1'b0);
        push_wr(4, 2'b00); push_wr(5, 2'b00);
        run(1'b1, 3'd6, 2'd1, 3, -2, 1'b1);
        // The locked cells now block the same placement.
        run(1'b0, 3'd6, 2'd1, 3, -2, 1'b1);

        // Reset during SCAN k=7 of a LOCK of horizontal I (cells k=4..7 -> addrs 63..66).
        clear_board();
        push_wr(63, 2'b01); push_wr(64, 2'b01); push_wr(65, 2'b01);
        @(posedge Clk); #1;
        mode = 1'b1; piece_id = 3'd1; rot = 2'd0; piece_x = 5'd3; piece_y = 6'd5;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        check("k7_brd_we", brd_we, 1);
        check("k7_brd_addr", brd_addr, 66);
        Reset_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_brd_we", brd_we, 0);
        check("rst_mid_brd_addr", brd_addr, 0);
        check("rst_mid_writes_seen", wr_q.size(), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        wr_q.delete();
        repeat (3) @(posedge Clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_collide", collide, 0);
        check("partial_write_kept", board[65], 2'b01);
        check("aborted_write_absent", board[66], 2'b11);
        run(1'b0, 3'd4, 2'd0, 3, 0, 1'b0);

        // Start held for 30 cycles: accepted at E0 and again at E20, nothing more.
        clear_board();
        @(posedge Clk); #1;
        mode = 1'b0; piece_id = 3'd4; rot = 2'd0; piece_x = 5'd3; piece_y = 6'd0;
        start = 1'b1;
        n0 = int'(cyc);
        done_q.push_back('{collide: 1'b0, cyc: 32'(n0 + 19)});
        done_q.push_back('{collide: 1'b0, cyc: 32'(n0 + 39)});
        scans_target += 2;
        repeat (30) @(posedge Clk);
        #1;
        start = 1'b0;
        wait_scans(60);
        repeat (30) @(posedge Clk);
        check("held_start_scan_count", scans_done, scans_target);
        check("held_start_queue_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
